// File: rtl/acc_cpu_gen2_if.sv
// Instruction-RAM and data-memory bus between the accumulator core and its memories.
interface acc_cpu_gen2_if #(parameter int W = 8);
    logic [W-1:0] iram_addr;
    logic [W+7:0] iram_dout;
    logic         dram_req;
    logic         dram_write;
    logic [W-1:0] dram_addr;
    logic [W-1:0] dram_din;
    logic         dram_ack;
    logic [W-1:0] dram_dout;

    modport master (
        output iram_addr, dram_req, dram_write, dram_addr, dram_din,
        input  iram_dout, dram_ack, dram_dout
    );

    modport slave (
        input  iram_addr, dram_req, dram_write, dram_addr, dram_din,
        output iram_dout, dram_ack, dram_dout
    );
endinterface

// File: rtl/acc_cpu_gen2.sv
// Accumulator CPU: synchronous instruction RAM, handshaked data memory, return stack.
// state | meaning: IDLE wait start; FETCH pc on iram; EXEC decode/execute; MEM wait dram_ack; FAULT stuck until rst
module acc_cpu_gen2 #(
    parameter int W           = 8,
    parameter int NUM_GPR     = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 idle,
    output logic                 fault,
    acc_cpu_gen2_if.master       bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [7:0] OP_END = 8'd0,  OP_ADD = 8'd1,  OP_SUB = 8'd2,  OP_MUL = 8'd3;
    localparam logic [7:0] OP_DV2 = 8'd4,  OP_NOT = 8'd5,  OP_LDK = 8'd6,  OP_LDM = 8'd7;
    localparam logic [7:0] OP_MVA = 8'd8,  OP_MVR = 8'd9,  OP_STM = 8'd10, OP_JMZ = 8'd11;
    localparam logic [7:0] OP_JMN = 8'd12, OP_CAL = 8'd13, OP_RET = 8'd14, OP_JMP = 8'd15;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_FAULT} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    pc, pc_nx, ac, ac_nx, din, din_nx, adr, adr_nx;
    logic [W-1:0]    gpr [NUM_GPR];
    logic [W-1:0]    stk [STACK_DEPTH];
    logic [SP_W-1:0] sp, sp_nx;
    logic            req, req_nx, wr, wr_nx;
    logic            gpr_we, push;
    logic [W-1:0]    rval, top, pc_inc;
    logic [7:0]      opc;
    logic [W-1:0]    opr;

    assign opc    = bus.iram_dout[7:0];
    assign opr    = bus.iram_dout[W+7:8];
    assign pc_inc = pc + W'(1);

    // Register-select read; codes past the last GPR read as zero
    always_comb begin
        rval = '0;
        if (opr == W'(0))      rval = ac;
        else if (opr == W'(1)) rval = din;
        else if (opr == W'(2)) rval = opr;
        else if (opr == W'(3)) rval = adr;
        else begin
            for (int i = 0; i < NUM_GPR; i++)
                if (opr == W'(i + 4)) rval = gpr[i];
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp == SP_W'(i + 1)) top = stk[i];
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ac_nx    = ac;
        din_nx   = din;
        adr_nx   = adr;
        sp_nx    = sp;
        req_nx   = req;
        wr_nx    = wr;
        gpr_we   = 1'b0;
        push     = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc_inc;
                case (opc)
                    OP_END: begin state_nx = S_IDLE; pc_nx = '0; sp_nx = '0; end
                    OP_ADD: ac_nx = ac + rval;
                    OP_SUB: ac_nx = ac - rval;
                    OP_MUL: ac_nx = ac * rval;
                    OP_DV2: ac_nx = {ac[W-1], ac[W-1:1]};
                    OP_NOT: ac_nx = ~ac;
                    OP_LDK: ac_nx = opr;
                    OP_MVA: ac_nx = rval;
                    OP_MVR: begin
                        gpr_we = 1'b1;
                        if (opr == W'(3)) adr_nx = ac;
                    end
                    OP_LDM: begin state_nx = S_MEM; pc_nx = pc; req_nx = 1'b1; wr_nx = 1'b0; end
                    OP_STM: begin state_nx = S_MEM; pc_nx = pc; req_nx = 1'b1; wr_nx = 1'b1; end
                    OP_JMZ: if (ac == '0) pc_nx = opr;
                    OP_JMN: if (ac[W-1]) pc_nx = opr;
                    OP_JMP: pc_nx = opr;
                    OP_CAL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            state_nx = S_FAULT;
                            pc_nx    = pc;
                        end else begin
                            push  = 1'b1;
                            sp_nx = sp + SP_W'(1);
                            pc_nx = opr;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            state_nx = S_FAULT;
                            pc_nx    = pc;
                        end else begin
                            sp_nx = sp - SP_W'(1);
                            pc_nx = top;
                        end
                    end
                    default: begin state_nx = S_FAULT; pc_nx = pc; end
                endcase
            end
            S_MEM: begin
                if (bus.dram_ack) begin
                    state_nx = S_FETCH;
                    pc_nx    = pc_inc;
                    req_nx   = 1'b0;
                    wr_nx    = 1'b0;
                    if (!wr) begin
                        din_nx = bus.dram_dout;
                        ac_nx  = bus.dram_dout;
                    end
                end
            end
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ac    <= '0;
            din   <= '0;
            adr   <= '0;
            sp    <= '0;
            req   <= 1'b0;
            wr    <= 1'b0;
            for (int i = 0; i < NUM_GPR; i++)     gpr[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ac    <= ac_nx;
            din   <= din_nx;
            adr   <= adr_nx;
            sp    <= sp_nx;
            req   <= req_nx;
            wr    <= wr_nx;
            for (int i = 0; i < NUM_GPR; i++)
                if (gpr_we && opr == W'(i + 4)) gpr[i] <= ac;
            for (int i = 0; i < STACK_DEPTH; i++)
                if (push && sp == SP_W'(i)) stk[i] <= pc_inc;
        end
    end

    assign idle           = (state == S_IDLE) || (state == S_FAULT);
    assign fault          = (state == S_FAULT);
    assign bus.iram_addr  = pc;
    assign bus.dram_req   = req;
    assign bus.dram_write = wr;
    assign bus.dram_addr  = adr;
    assign bus.dram_din   = ac;
endmodule

// File: tb/tb_acc_cpu_gen2.sv
// Directed bench for acc_cpu_gen2: programs in a bench instruction RAM, data-memory traffic scoreboarded.
module tb_acc_cpu_gen2;
    localparam logic [7:0] END_ = 8'd0,  ADD = 8'd1,  SUB = 8'd2,  MUL = 8'd3;
    localparam logic [7:0] DV2  = 8'd4,  NOT_ = 8'd5, LDK = 8'd6,  LDM = 8'd7;
    localparam logic [7:0] MVA  = 8'd8,  MVR = 8'd9,  STM = 8'd10, JMZ = 8'd11;
    localparam logic [7:0] JMN  = 8'd12, CAL = 8'd13, RET = 8'd14, JMP = 8'd15;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         dly;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic idle, fault;
    int   checks = 0;
    int   failures = 0;
    int   cyc;
    txn_t sb[$];
    logic [15:0] imem [256];

    acc_cpu_gen2_if #(.W(8)) bus ();

    acc_cpu_gen2 #(.W(8), .NUM_GPR(8), .STACK_DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .idle  (idle),
        .fault (fault),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.iram_dout <= imem[bus.iram_addr];

    function automatic logic [15:0] ins(input logic [7:0] opc, input logic [7:0] opr);
        return {opr, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int k = 0; k < 256; k++) imem[k] = 16'h0000;
    endtask

    task automatic exp_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input int dly);
        txn_t t;
        t.w = w; t.a = a; t.d = d; t.dly = dly;
        sb.push_back(t);
    endtask

    task automatic run_prog(input int max_cyc, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (idle !== 1'b1 && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_reaches_idle", {31'b0, idle}, 1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_idle", {31'b0, idle}, 1);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_pc", {24'b0, bus.iram_addr}, 0);
        chk("rst_dram_req", {31'b0, bus.dram_req}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Data-memory responder and scoreboard checker
    initial begin
        int         req_len;
        logic       unstable;
        logic [7:0] a0, d0;
        logic       w0;
        txn_t       t;
        req_len = 0;
        unstable = 1'b0;
        a0 = '0; d0 = '0; w0 = 1'b0;
        bus.dram_ack  = 1'b0;
        bus.dram_dout = '0;
        forever begin
            @(negedge clk);
            bus.dram_ack = 1'b0;
            if (bus.dram_req === 1'b1) begin
                if (req_len == 0) begin
                    a0 = bus.dram_addr; d0 = bus.dram_din; w0 = bus.dram_write; unstable = 1'b0;
                end else if (bus.dram_addr !== a0 || bus.dram_din !== d0 || bus.dram_write !== w0) begin
                    unstable = 1'b1;
                end
                req_len++;
                if (sb.size() == 0) begin
                    chk("spurious_dram_req", {31'b0, bus.dram_req}, 0);
                    bus.dram_ack = 1'b1;
                end else if (req_len > sb[0].dly) begin
                    t = sb.pop_front();
                    chk("mem_write", {31'b0, bus.dram_write}, {31'b0, t.w});
                    chk("mem_addr", {24'b0, bus.dram_addr}, {24'b0, t.a});
                    if (t.w) chk("mem_store_data", {24'b0, bus.dram_din}, {24'b0, t.d});
                    chk("mem_req_stable", {31'b0, unstable}, 0);
                    bus.dram_dout = t.d;
                    bus.dram_ack  = 1'b1;
                end
            end else begin
                req_len = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        clear_imem();

        // Reset held with start asserted: core must stay idle
        @(posedge clk);
        #1;
        chk("reset_idle", {31'b0, idle}, 1);
        chk("reset_fault", {31'b0, fault}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_start_ignored", {31'b0, idle}, 1);
        chk("reset_pc", {24'b0, bus.iram_addr}, 0);
        chk("reset_dram_req", {31'b0, bus.dram_req}, 0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset_release", {31'b0, idle}, 1);

        // Five-instruction program: 10 cycles, then values retained across END
        imem[0] = ins(LDK, 8'd5);
        imem[1] = ins(MVR, 8'd4);
        imem[2] = ins(LDK, 8'd3);
        imem[3] = ins(ADD, 8'd4);
        imem[4] = ins(END_, 8'd0);
        run_prog(100, cyc);
        chk("prog1_cycles", cyc, 10);
        chk("prog1_no_fault", {31'b0, fault}, 0);
        chk("prog1_pc_zero", {24'b0, bus.iram_addr}, 0);

        clear_imem();
        imem[0] = ins(STM, 8'd0);
        imem[1] = ins(MVA, 8'd4);
        imem[2] = ins(STM, 8'd0);
        exp_txn(1'b1, 8'h00, 8'h08, 0);
        exp_txn(1'b1, 8'h00, 8'h05, 0);
        run_prog(100, cyc);

        // Arithmetic, branches and register-select corner cases
        clear_imem();
        imem[0]  = ins(LDK, 8'd1);
        imem[1]  = ins(MVR, 8'd5);
        imem[2]  = ins(LDK, 8'h80);
        imem[3]  = ins(DV2, 8'd0);
        imem[4]  = ins(STM, 8'd0);
        imem[5]  = ins(JMN, 8'd8);
        imem[6]  = ins(LDK, 8'h11);
        imem[7]  = ins(STM, 8'd0);
        imem[8]  = ins(LDK, 8'd0);
        imem[9]  = ins(JMZ, 8'd12);
        imem[10] = ins(LDK, 8'h22);
        imem[11] = ins(STM, 8'd0);
        imem[12] = ins(SUB, 8'd5);
        imem[13] = ins(STM, 8'd0);
        imem[14] = ins(NOT_, 8'd0);
        imem[15] = ins(STM, 8'd0);
        imem[16] = ins(LDK, 8'd3);
        imem[17] = ins(MVR, 8'd6);
        imem[18] = ins(LDK, 8'h56);
        imem[19] = ins(MUL, 8'd6);
        imem[20] = ins(STM, 8'd0);
        imem[21] = ins(LDK, 8'hFD);
        imem[22] = ins(DV2, 8'd0);
        imem[23] = ins(STM, 8'd0);
        imem[24] = ins(LDK, 8'h77);
        imem[25] = ins(MVR, 8'd12);
        imem[26] = ins(MVA, 8'd12);
        imem[27] = ins(STM, 8'd0);
        imem[28] = ins(LDK, 8'h44);
        imem[29] = ins(MVR, 8'd1);
        imem[30] = ins(MVA, 8'd1);
        imem[31] = ins(STM, 8'd0);
        imem[32] = ins(ADD, 8'd4);
        imem[33] = ins(ADD, 8'd2);
        imem[34] = ins(JMP, 8'd37);
        imem[35] = ins(LDK, 8'h33);
        imem[36] = ins(STM, 8'd0);
        imem[37] = ins(STM, 8'd0);
        imem[38] = ins(JMN, 8'd41);
        imem[39] = ins(LDK, 8'h66);
        imem[40] = ins(STM, 8'd0);
        exp_txn(1'b1, 8'h00, 8'hC0, 0);
        exp_txn(1'b1, 8'h00, 8'hFF, 0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        exp_txn(1'b1, 8'h00, 8'h02, 0);
        exp_txn(1'b1, 8'h00, 8'hFE, 0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        exp_txn(1'b1, 8'h00, 8'h07, 0);
        exp_txn(1'b1, 8'h00, 8'h66, 0);
        run_prog(400, cyc);

        // Late ack on store, then load of 0x5A into AC and DIN
        clear_imem();
        imem[0] = ins(LDK, 8'h30);
        imem[1] = ins(MVR, 8'd3);
        imem[2] = ins(LDK, 8'hA5);
        imem[3] = ins(STM, 8'd0);
        imem[4] = ins(LDM, 8'd0);
        imem[5] = ins(STM, 8'd0);
        imem[6] = ins(LDK, 8'd0);
        imem[7] = ins(MVA, 8'd1);
        imem[8] = ins(STM, 8'd0);
        exp_txn(1'b1, 8'h30, 8'hA5, 3);
        exp_txn(1'b0, 8'h30, 8'h5A, 1);
        exp_txn(1'b1, 8'h30, 8'h5A, 0);
        exp_txn(1'b1, 8'h30, 8'h5A, 0);
        run_prog(200, cyc);
        chk("mem_prog_cycles", cyc, 28);

        // Nested CAL/RET within a two-entry stack
        clear_imem();
        imem[0]  = ins(CAL, 8'd10);
        imem[1]  = ins(STM, 8'd0);
        imem[10] = ins(LDK, 8'd1);
        imem[11] = ins(CAL, 8'd20);
        imem[12] = ins(STM, 8'd0);
        imem[13] = ins(LDK, 8'd3);
        imem[14] = ins(RET, 8'd0);
        imem[20] = ins(LDK, 8'd2);
        imem[21] = ins(RET, 8'd0);
        exp_txn(1'b1, 8'h30, 8'h02, 0);
        exp_txn(1'b1, 8'h30, 8'h03, 0);
        run_prog(200, cyc);
        chk("call_ret_no_fault", {31'b0, fault}, 0);

        // Third nested CAL overflows
        clear_imem();
        imem[0]  = ins(CAL, 8'd10);
        imem[10] = ins(CAL, 8'd20);
        imem[20] = ins(CAL, 8'd30);
        run_prog(100, cyc);
        chk("overflow_fault", {31'b0, fault}, 1);
        chk("overflow_pc_held", {24'b0, bus.iram_addr}, 20);
        chk("overflow_cycles", cyc, 6);
        do_reset();

        // END empties the stack, so a following RET faults
        clear_imem();
        imem[0] = ins(CAL, 8'd5);
        imem[5] = ins(END_, 8'd0);
        run_prog(100, cyc);
        chk("end_no_fault", {31'b0, fault}, 0);
        clear_imem();
        imem[0] = ins(RET, 8'd0);
        run_prog(100, cyc);
        chk("ret_empty_fault", {31'b0, fault}, 1);
        chk("ret_empty_pc_held", {24'b0, bus.iram_addr}, 0);
        do_reset();

        // Illegal opcode faults; start ignored; reset clears registers
        clear_imem();
        imem[0] = ins(LDK, 8'h99);
        imem[1] = ins(MVR, 8'd4);
        imem[2] = ins(8'h20, 8'd0);
        run_prog(100, cyc);
        chk("illegal_fault", {31'b0, fault}, 1);
        chk("illegal_pc_held", {24'b0, bus.iram_addr}, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fault_start_ignored", {31'b0, fault}, 1);
        chk("fault_pc_still_held", {24'b0, bus.iram_addr}, 2);
        do_reset();
        clear_imem();
        imem[0] = ins(STM, 8'd0);
        imem[1] = ins(MVA, 8'd4);
        imem[2] = ins(STM, 8'd0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        run_prog(100, cyc);

        // Reset during a load that is never acknowledged
        clear_imem();
        imem[0] = ins(LDK, 8'h42);
        imem[1] = ins(MVR, 8'd3);
        imem[2] = ins(LDK, 8'h55);
        imem[3] = ins(MVR, 8'd4);
        imem[4] = ins(LDM, 8'd0);
        exp_txn(1'b0, 8'h42, 8'hEE, 1000);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (bus.dram_req !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("abort_req_seen", {31'b0, bus.dram_req}, 1);
        repeat (2) @(posedge clk);
        do_reset();
        sb.delete();
        clear_imem();
        imem[0] = ins(STM, 8'd0);
        imem[1] = ins(MVA, 8'd4);
        imem[2] = ins(STM, 8'd0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        exp_txn(1'b1, 8'h00, 8'h00, 0);
        run_prog(100, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acc_cpu_gen2.md
ACC_CPU_GEN2 -- requirements
Module: acc_cpu_gen2

Interface
REQ-001 Parameter W, default 8: data, operand and address width in bits (legal range 8-16).
REQ-002 Parameter NUM_GPR, default 8: number of general purpose registers (legal range 1-12).
REQ-003 Parameter STACK_DEPTH, default 4: number of return-stack entries (legal range 1-16).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin execution at address 0 when the core is idle.
REQ-007 idle  out  1  high in IDLE or FAULT state.
REQ-008 fault  out  1  high in FAULT state.
REQ-009 iram_addr  out  W  instruction address (equals pc).
REQ-010 iram_dout  in  W+8  instruction word {opr[W-1:0], opc[7:0]}, valid one cycle after the address (synchronous RAM).
REQ-011 dram_req  out  1  data-memory request, held until ack.
REQ-012 dram_write  out  1  1 = store, 0 = load; valid while dram_req is high.
REQ-013 dram_addr  out  W  equals ADR register.
REQ-014 dram_din  out  W  store data, equals AC.
REQ-015 dram_ack  in  1  completes the request in the cycle it is high.
REQ-016 dram_dout  in  W  load data, sampled in the cycle dram_ack is high.

Function
REQ-017 States SHALL be IDLE, FETCH, EXEC, MEM, FAULT; IDLE->FETCH on start; FETCH->EXEC always; EXEC->FETCH|MEM|IDLE|FAULT per opcode; MEM->FETCH on dram_ack; FAULT->IDLE only via rst.
REQ-018 Register-select codes: 0 AC, 1 DIN, 2 OPR, 3 ADR, 4..3+NUM_GPR GPR[0..]; a code above 3+NUM_GPR SHALL read 0 and write nothing.
REQ-019 Opcodes: 0 END, 1 ADD, 2 SUB, 3 MUL, 4 DV2, 5 NOT, 6 LDK, 7 LDM, 8 MVA, 9 MVR, 10 STM, 11 JMZ, 12 JMN, 13 CAL, 14 RET, 15 JMP; opcodes 16-255 SHALL enter FAULT.
REQ-020 ADD/SUB/MUL: AC <= AC op reg[opr], result truncated to low W bits, two's complement.
REQ-021 DV2: AC <= arithmetic shift right of AC by 1 (-3 -> -2); NOT: AC <= bitwise inverse of AC.
REQ-022 LDK: AC <= opr; MVA: AC <= reg[opr]; MVR: reg[opr] <= AC (writes to DIN or OPR codes are ignored).
REQ-023 LDM: EXEC->MEM with dram_req=1, dram_write=0; on dram_ack: DIN <= dram_dout, AC <= dram_dout.
REQ-024 STM: EXEC->MEM with dram_req=1, dram_write=1, dram_din=AC; complete on dram_ack; no register changes.
REQ-025 dram_req SHALL rise in the EXEC cycle and stay high, with addr/data/write stable, until the dram_ack cycle inclusive, then fall.
REQ-026 JMZ/JMN: pc <= opr if AC==0 / AC<0 (signed), else pc+1; JMP: pc <= opr unconditionally.
REQ-027 CAL: push pc+1, pc <= opr; RET: pop into pc; CAL on full stack or RET on empty stack SHALL enter FAULT with pc and stack unchanged.
REQ-028 All other non-END opcodes SHALL set pc <= pc+1 (modulo 2^W) at the end of EXEC (or MEM for LDM/STM).
REQ-029 END: pc <= 0, stack emptied, state -> IDLE; AC/GPR/ADR/DIN retained.
REQ-030 Latency: non-memory instruction 2 cycles; LDM/STM 3 cycles plus one per cycle dram_ack is late.
REQ-031 start SHALL be ignored outside IDLE; start in IDLE with the same-cycle state transition SHALL fetch address pc (0).

Reset
REQ-032 rst SHALL force, at the next edge and regardless of state (including mid-MEM): state=IDLE, pc=0, AC=ADR=DIN=0, all GPR=0, stack empty, fault=0, dram_req=0, dram_write=0.
REQ-033 While rst is high idle SHALL read 1 after the first edge, and start SHALL be ignored.

Verification
REQ-034 Program LDK 5; MVR 4; LDK 3; ADD 4; END with W=8 -> AC=8, GPR[0]=5, idle after exactly 10 cycles from start.
REQ-035 LDK 0x80 (W=8); DV2 -> AC=0xC0; JMN target taken; LDK 0; JMZ taken; SUB of 1 from 0 -> AC=0xFF.
REQ-036 STM with dram_ack delayed 3 cycles -> dram_req high 4 cycles, addr/data stable, then LDM returns 0x5A into AC and DIN.
REQ-037 STACK_DEPTH=2: CAL, CAL, RET, RET returns correctly; third nested CAL -> fault=1, idle=1, pc held at the CAL address.
REQ-038 Opcode 0x20 -> FAULT; start ignored; rst pulse -> idle=1, fault=0, pc=0, AC=0; next start runs from address 0.
REQ-039 Assert rst during MEM with dram_ack low -> dram_req=0 next cycle, state IDLE, no register updated.
